// File: rtl/conv_window_gen_if.sv
// Stream-in / window-out bundle for the sliding-window generator.
// The block itself uses the slave side; the pixel source and window consumer use the master side.
interface conv_window_gen_if #(
   parameter int DATA_W = 8,
   parameter int K      = 3
);
   logic [DATA_W-1:0]     s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic                  s_axis_tlast;
   logic [K*K*DATA_W-1:0] win_data;
   logic                  win_valid;
   logic                  win_ready;
   logic                  win_sop;
   logic                  win_eop;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, win_ready,
      output s_axis_tready, win_data, win_valid, win_sop, win_eop
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, win_ready,
      input  s_axis_tready, win_data, win_valid, win_sop, win_eop
   );
endinterface

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator: K-1 line buffers plus a KxK shift window.
// One raster pixel in per beat, one full window out per valid position.
module conv_window_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int K      = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   conv_window_gen_if.slave bus,
   output logic             frame_done,
   output logic             err_frame,
   input  logic             err_clr
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

   typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

   state_t                          state, state_n;
   logic [CW-1:0]                   col, col_n;
   logic [RW-1:0]                   row, row_n;
   logic                            rdy_en;
   logic                            accept, last_pix, early, shift_en, emit;
   logic [K-1:0][DATA_W-1:0]        col_vec;
   logic [K-1:0][K-1:0][DATA_W-1:0] win;
   logic [DATA_W-1:0]               lb [K-1][IMG_W];

   // rdy_en keeps tready low until the first clock after reset release
   assign bus.s_axis_tready = rdy_en && (!bus.win_valid || bus.win_ready);
   assign accept   = bus.s_axis_tvalid && bus.s_axis_tready;
   assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
   assign early    = accept && bus.s_axis_tlast && !last_pix;
   assign shift_en = accept && !early;
   assign emit     = shift_en && (row >= ROW_WIN) && (col >= COL_WIN);

   assign bus.win_data = win;
   assign frame_done   = (state == DONE);

   // column vector: lane 0 is the oldest row, lane K-1 the incoming pixel
   generate
      for (genvar i = 0; i < K - 1; i++) begin : g_lb_rd
         assign col_vec[i] = lb[i][col];
      end
   endgenerate
   assign col_vec[K-1] = bus.s_axis_tdata;

   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      if (accept) begin
         if (early || last_pix) begin
            col_n   = '0;
            row_n   = '0;
            state_n = early ? IDLE : DONE;
         end else begin
            if (col == COL_LAST) begin
               col_n = '0;
               row_n = row + 1'b1;
            end else begin
               col_n = col + 1'b1;
            end
            state_n = (row_n >= ROW_WIN) ? STREAM : FILL;
         end
      end else if (state == DONE) begin
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         col           <= '0;
         row           <= '0;
         rdy_en        <= 1'b0;
         bus.win_valid <= 1'b0;
         bus.win_sop   <= 1'b0;
         bus.win_eop   <= 1'b0;
         err_frame     <= 1'b0;
      end else begin
         state  <= state_n;
         col    <= col_n;
         row    <= row_n;
         rdy_en <= 1'b1;
         // single output slot: an accept may overwrite it because tready implies it drains
         if (accept) begin
            bus.win_valid <= emit;
            bus.win_sop   <= emit && (row == ROW_WIN) && (col == COL_WIN);
            bus.win_eop   <= emit && last_pix;
         end else if (bus.win_ready) begin
            bus.win_valid <= 1'b0;
         end
         if (accept && (early || (last_pix && !bus.s_axis_tlast)))
            err_frame <= 1'b1;
         else if (err_clr)
            err_frame <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win <= '0;
      end else if (shift_en) begin
         for (int r = 0; r < K; r++)
            win[r] <= {col_vec[r], win[r][K-1:1]};
      end
   end

   // line buffers carry no reset: FILL rewrites every entry before it is read into a window
   always_ff @(posedge clk) begin
      if (shift_en) begin
         for (int i = 0; i < K - 1; i++)
            lb[i][col] <= col_vec[i+1];
      end
   end
endmodule
